snn_stack: RTL and testbench
============================

# snn_stack

Parametrised multi-layer leaky integrate-and-fire spiking network with a serially loaded configuration. The block replaces hard-wired three-layer wiring with LAYERS × N neurons, per-layer leak, threshold and refractory control, and signed saturating membrane arithmetic. It sits between the chip pin interface and the spike outputs. The configuration is loaded one bit per clock, so the block fits a narrow pin budget.

## Interface
Parameters:
- LAYERS, 3, number of cascaded layers (≥1)
- N, 3, neurons per layer, equal to the external input width
- W_W, 8, signed weight width
- V_W, 12, signed membrane potential / threshold width
- CFG_W, LAYERS*(V_W+3+4+N*N*W_W), derived total config length; not to be overridden

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active low
- enable  in  1  one network update (tick) per cycle sampled high
- input_spikes  in  N  external spikes into layer 0
- cfg_en  in  1  configuration mode; shifts cfg_bit each cycle
- cfg_bit  in  1  serial config data, first bit = config MSB
- output_spikes  out  N  registered spikes of last layer
- out_valid  out  1  one-cycle pulse: output_spikes updated this cycle

## Operation
- Config register CFG_W bits. When cfg_en=1, each cycle: cfg <= {cfg[CFG_W-2:0], cfg_bit}. After CFG_W cycles, the first bit shifted in is the MSB.
- Layout, MSB first, layer 0 first. Per layer segment: threshold[V_W] signed, leak[3], refr[4], then weights N*N*W_W. Weight for (post j, pre i) is ordered j-major, then i, with (0,0) most significant.
- Per-neuron state: v (signed V_W), rc (4-bit refractory count), spike (1 bit).
- Tick, when enable=1 and cfg_en=0. All layers update on the same edge.
  - Layer l input is the registered spike vector of layer l-1. Layer 0 uses input_spikes.
  - If rc≠0: rc<=rc-1, v<=0, spike<=0.
  - Else compute in ≥V_W+ceil(log2 N)+1 bits: leak term lv = v if leak==0, else v-(v>>>leak) (arithmetic shift, rounds toward −inf). Then s = lv + Σ weight(j,i) over pre-spikes i.
  - Saturate s to [−2^(V_W−1), 2^(V_W−1)−1].
  - If sat(s) ≥ threshold (signed): spike<=1, v<=0, rc<=refr. Else spike<=0, v<=sat(s).
- enable=0, cfg_en=0: all state held, output_spikes held.
- cfg_en=1: all v, rc and spike forced to 0 every cycle, so output_spikes=0 and out_valid=0. enable is ignored. The config is the only thing that changes.
- output_spikes = last layer spike register. out_valid <= (enable & ~cfg_en) registered.

## Timing
- Reset, asynchronous assertion: v=0, rc=0, all spikes 0, output_spikes=0, out_valid=0.
- Reset config value: all fields 0 except every threshold = 2^(V_W−1)−1. Weights are therefore 0 and nothing fires.
- Reset release is synchronous to clk. The first update can occur on the first edge with rst_n=1.
- Latency: an input spike present at tick k can first reach output_spikes after tick k+LAYERS−1. With LAYERS=3 it is visible after the 3rd tick.
- out_valid is high in the cycle following each tick, coincident with the new output_spikes.
- Back-to-back ticks are allowed every cycle, with no stall.
- cfg_en and enable both high: configuration wins and no tick occurs.
- Config bits take effect on the tick after cfg_en drops. A partial load leaves a shifted, mixed config. This is legal and not flagged.
- refr=R: after a spike the neuron is silent for exactly R ticks. R=0 means it may fire on consecutive ticks.

## Test plan
- Reset: drive rst_n=0 mid-run with spikes active → output_spikes=0 and out_valid=0 immediately without a clock edge. After release with enable=1 and input 3'b111, output stays 0 (default thresholds).
- Identity chain: load all layers with diagonal weight 100, off-diagonal 0, threshold 50, leak 0, refr 0. Hold input 3'b001 with enable=1 → output 3'b000 after ticks 1–2, 3'b001 from tick 3 onward, out_valid every cycle.
- Leak: layer 0 diagonal weight 20, threshold 100.
  - leak 0 → neuron 0 v = 20, 40, 60, 80, then spikes on tick 5.
  - leak 1 → v = 20, 30, 35, 38, 39, 40, 40…, never spikes.
- Refractory: weight 100, threshold 50, refr 2, constant input → layer 0 neuron 0 spike pattern 1,0,0,1,0,0,1.
- Saturation: all weights +127 into neuron 0, threshold 2047, input 3'b111 → v = 381, 762, …, 1905, then clamps to 2047 and spikes on tick 6. All weights −128 with threshold 2047 → v pins at −2048 and never wraps.
- Mode interplay:
  - enable low for 5 cycles mid-run → state and output frozen, out_valid=0.
  - Raise cfg_en mid-run → spikes and v cleared next edge.
  - cfg_en and enable both high → no tick.

Source files
------------

// File: rtl/snn_stack.sv
// snn_stack: LAYERS cascaded layers of N leaky integrate-and-fire neurons.
// Every layer has its own threshold, leak shift, refractory length and an
// N x N weight matrix. All of these come from one serially loaded
// configuration register.
module snn_stack #(
  parameter int LAYERS = 3,
  parameter int N      = 3,
  parameter int W_W    = 8,
  parameter int V_W    = 12,
  parameter int CFG_W  = LAYERS * (V_W + 3 + 4 + N * N * W_W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] input_spikes,
  input  logic         cfg_en,
  input  logic         cfg_bit,
  output logic [N-1:0] output_spikes,
  output logic         out_valid
);

  localparam int SEG_W = V_W + 3 + 4 + N * N * W_W;
  localparam int LOG_N = (N > 1) ? $clog2(N) : 1;
  // Headroom for the potential plus N weights, taking the wider operand.
  localparam int ACC_W = ((V_W > W_W) ? V_W : W_W) + LOG_N + 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-V_W+1){1'b0}}, {(V_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-V_W+1){1'b1}}, {(V_W-1){1'b0}}};
  localparam logic [V_W-1:0] THR_RST = {1'b0, {(V_W-1){1'b1}}};

  // Reset config: every threshold is at the positive maximum and all other fields are zero.
  function automatic logic [CFG_W-1:0] cfg_reset_value();
    logic [CFG_W-1:0] c;
    c = '0;
    for (int l = 0; l < LAYERS; l++) begin
      c[(LAYERS-l)*SEG_W-1 -: V_W] = THR_RST;
    end
    return c;
  endfunction

  localparam logic [CFG_W-1:0] CFG_RST = cfg_reset_value();

  logic [CFG_W-1:0] r_cfg;
  logic             r_out_valid;
  logic [N-1:0]     w_layer_spikes [LAYERS];

  // Serial configuration shift register. The first bit loaded ends up as the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= CFG_RST;
    end else if (cfg_en) begin
      r_cfg <= {r_cfg[CFG_W-2:0], cfg_bit};
    end
  end

  // out_valid marks the cycle after a tick. Configuration mode suppresses the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= enable & ~cfg_en;
    end
  end

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
    // Layer 0 occupies the most significant segment.
    localparam int TOP   = (LAYERS - gi) * SEG_W - 1;
    localparam int WBASE = (LAYERS - 1 - gi) * SEG_W;

    logic signed [V_W-1:0] w_thr;
    logic [2:0]            w_leak;
    logic [3:0]            w_refr;
    logic signed [W_W-1:0] w_wt [N*N];
    logic [N-1:0]          w_pre;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [V_W-1:0] w_sat;
    logic signed [V_W-1:0] w_v_next [N];
    logic [3:0]            w_rc_next [N];
    logic [N-1:0]          w_spike_next;
    logic signed [V_W-1:0] r_v [N];
    logic [3:0]            r_rc [N];
    logic [N-1:0]          r_spike;

    assign w_thr  = r_cfg[TOP -: V_W];
    assign w_leak = r_cfg[TOP-V_W -: 3];
    assign w_refr = r_cfg[TOP-V_W-3 -: 4];

    // Weight index k = post*N + pre. k = 0 is the most significant weight.
    for (genvar gk = 0; gk < N * N; gk++) begin : g_wt
      assign w_wt[gk] = r_cfg[WBASE + (N*N-1-gk)*W_W +: W_W];
    end

    if (gi == 0) begin : g_src_in
      assign w_pre = input_spikes;
    end else begin : g_src_prev
      assign w_pre = w_layer_spikes[gi-1];
    end

    assign w_layer_spikes[gi] = r_spike;

    // Next state for each neuron: leak, integrate, saturate, then test against the threshold.
    always_comb begin
      w_acc        = '0;
      w_sat        = '0;
      w_spike_next = '0;
      for (int j = 0; j < N; j++) begin
        w_v_next[j]  = '0;
        w_rc_next[j] = '0;
      end
      for (int j = 0; j < N; j++) begin
        w_acc = {{(ACC_W-V_W){r_v[j][V_W-1]}}, r_v[j]};
        if (w_leak != 3'd0) begin
          w_acc = w_acc - (w_acc >>> w_leak);
        end
        for (int i = 0; i < N; i++) begin
          if (w_pre[i]) begin
            w_acc = w_acc + {{(ACC_W-W_W){w_wt[j*N+i][W_W-1]}}, w_wt[j*N+i]};
          end
        end
        if (w_acc > ACC_MAX) begin
          w_sat = ACC_MAX[V_W-1:0];
        end else if (w_acc < ACC_MIN) begin
          w_sat = ACC_MIN[V_W-1:0];
        end else begin
          w_sat = w_acc[V_W-1:0];
        end
        if (r_rc[j] != 4'd0) begin
          w_rc_next[j] = r_rc[j] - 4'd1;
        end else if (w_sat >= w_thr) begin
          w_spike_next[j] = 1'b1;
          w_rc_next[j]    = w_refr;
        end else begin
          w_v_next[j] = w_sat;
        end
      end
    end

    // Neuron state: cleared in config mode, advanced on a tick, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_spike <= '0;
        for (int j = 0; j < N; j++) begin
          r_v[j]  <= '0;
          r_rc[j] <= '0;
        end
      end else if (cfg_en) begin
        r_spike <= '0;
        for (int j = 0; j < N; j++) begin
          r_v[j]  <= '0;
          r_rc[j] <= '0;
        end
      end else if (enable) begin
        r_spike <= w_spike_next;
        for (int j = 0; j < N; j++) begin
          r_v[j]  <= w_v_next[j];
          r_rc[j] <= w_rc_next[j];
        end
      end
    end
  end

  assign output_spikes = w_layer_spikes[LAYERS-1];
  assign out_valid     = r_out_valid;

endmodule

// File: tb/tb_snn_stack.sv
// tb_snn_stack: directed scoreboard bench for snn_stack with the default
// 3x3 geometry. The stimulus pushes the expected output of each tick, and
// the monitor pops one entry and compares it whenever out_valid is high.
module tb_snn_stack;

  localparam int L   = 3;
  localparam int NN  = 3;
  localparam int WW  = 8;
  localparam int VW  = 12;
  localparam int SEG = VW + 3 + 4 + NN * NN * WW;
  localparam int CW  = L * SEG;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_en = 1'b0;
  logic       cfg_bit = 1'b0;
  logic [2:0] input_spikes = 3'b000;
  logic [2:0] output_spikes;
  logic       out_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q [$];

  snn_stack #(.LAYERS(L), .N(NN), .W_W(WW), .V_W(VW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .input_spikes  (input_spikes),
    .cfg_en        (cfg_en),
    .cfg_bit       (cfg_bit),
    .output_spikes (output_spikes),
    .out_valid     (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard comparison per valid output.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got out=%b with no expected entry", output_spikes);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (output_spikes !== e) begin
          n_fail++;
          $display("FAIL tick_out: got %b expected %b", output_spikes, e);
        end else begin
          $display("[TB] tick out=%b exp=%b ok", output_spikes, e);
        end
      end
    end
  end

  function automatic logic [71:0] diag_w(input logic [7:0] d);
    logic [71:0] w;
    w = '0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++)
        if (i == j) w[(8 - (j*3 + i))*8 +: 8] = d;
    return w;
  endfunction

  function automatic logic [71:0] row0_w(input logic [7:0] d);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) w[(8 - i)*8 +: 8] = d;
    return w;
  endfunction

  function automatic logic [SEG-1:0] seg(input logic [11:0] thr, input logic [2:0] lk,
                                         input logic [3:0] rf, input logic [71:0] w);
    return {thr, lk, rf, w};
  endfunction

  // Serial load. enable is held high as well, so the config-over-tick priority is exercised.
  task automatic load_cfg(input logic [CW-1:0] c);
    for (int k = 0; k < CW; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("cfg_valid_low", {31'd0, out_valid}, 32'd0);
        check("cfg_out_zero", {29'd0, output_spikes}, 32'd0);
      end
      cfg_en  = 1'b1;
      enable  = 1'b1;
      cfg_bit = c[CW-1-k];
    end
    @(negedge clk);
    check("cfg_valid_low", {31'd0, out_valid}, 32'd0);
    check("cfg_out_zero", {29'd0, output_spikes}, 32'd0);
    cfg_en = 1'b0;
    enable = 1'b0;
  endtask

  task automatic tick(input logic [2:0] in, input logic [2:0] e);
    @(negedge clk);
    cfg_en = 1'b0;
    enable = 1'b1;
    input_spikes = in;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [2:0] in, input int n, input logic [31:0] pat);
    for (int t = 0; t < n; t++) tick(in, {2'b00, pat[t]});
  endtask

  task automatic idle(input int n, input logic [2:0] hold);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("hold_valid_low", {31'd0, out_valid}, 32'd0);
        check("hold_out", {29'd0, output_spikes}, {29'd0, hold});
      end
      enable = 1'b0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    enable = 1'b0;
    input_spikes = 3'b000;
  endtask

  initial begin
    logic [SEG-1:0] id_seg;
    logic [11:0]    pv;
    id_seg = seg(12'd50, 3'd0, 4'd0, diag_w(8'd100));

    // Reset state without any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("rst_out", {29'd0, output_spikes}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(3'b111, 3, 32'h0);

    // Identity chain: 3-tick latency, then back-to-back freeze and resume.
    load_cfg({id_seg, id_seg, id_seg});
    run(3'b001, 5, 32'b11100);
    idle(6, 3'b001);
    tick(3'b001, 3'b001);

    // Reloading mid-run clears the state, so the latency restarts.
    load_cfg({id_seg, id_seg, id_seg});
    run(3'b001, 3, 32'b100);

    // Asynchronous reset while spikes are active.
    @(posedge clk);
    #1;
    check("pre_rst_out", {29'd0, output_spikes}, 32'd1);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async_rst_out", {29'd0, output_spikes}, 32'd0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(3'b111, 3, 32'h0);

    // Leak 0: layer 0 fires on ticks 5 and 10, seen at the output on ticks 7 and 12.
    load_cfg({seg(12'd100, 3'd0, 4'd0, diag_w(8'd20)), id_seg, id_seg});
    run(3'b001, 12, 32'h840);

    // Leak 1, threshold 40: v = 20,30,35,38,39, then reaches 40 and fires on tick 6.
    load_cfg({seg(12'd40, 3'd1, 4'd0, diag_w(8'd20)), id_seg, id_seg});
    run(3'b001, 10, 32'h080);

    // Leak 1, threshold 100: settles at 40 and never fires.
    load_cfg({seg(12'd100, 3'd1, 4'd0, diag_w(8'd20)), id_seg, id_seg});
    run(3'b001, 7, 32'h0);
    settle();
    pv = dut.g_layer[0].r_v[0];
    check("leak1_v_steady", {20'd0, pv}, 32'd40);

    // Refractory 2: layer 0 fires on ticks 1,4,7. Freezes are inserted mid-sequence.
    load_cfg({seg(12'd50, 3'd0, 4'd2, diag_w(8'd100)), id_seg, id_seg});
    for (int t = 1; t <= 9; t++) begin
      tick(3'b001, (t % 3 == 0) ? 3'b001 : 3'b000);
      if (t == 2) idle(6, 3'b000);
      if (t == 6) idle(6, 3'b001);
    end

    // Positive saturation: 381 per tick, clamps to 2047 and fires on tick 6.
    load_cfg({seg(12'd2047, 3'd0, 4'd0, row0_w(8'd127)), id_seg, id_seg});
    run(3'b111, 9, 32'h080);

    // Negative saturation: -384 per tick pins at -2048.
    load_cfg({seg(12'd2047, 3'd0, 4'd0, row0_w(8'h80)), id_seg, id_seg});
    run(3'b111, 7, 32'h0);
    settle();
    pv = dut.g_layer[0].r_v[0];
    check("neg_sat_v", {20'd0, pv}, 32'h800);

    settle();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
